// File: rtl/merge_2.sv
// Two-to-one stream merger: burst-limited round-robin arbiter feeding a single
// registered output stage that tags each word with its source index.
module merge_2 #(
    parameter int N     = 8,
    parameter int BURST = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] data1_i,
    input  logic         valid1_i,
    output logic         ready1_o,
    input  logic [N-1:0] data2_i,
    input  logic         valid2_i,
    output logic         ready2_o,
    output logic [N-1:0] data_o,
    output logic         valid_o,
    output logic         src_o,
    input  logic         ready_i
);
    localparam int              CW      = $clog2(BURST + 1);
    localparam logic [CW-1:0]   BURST_C = CW'(BURST);

    typedef enum logic {
        SRC1 = 1'b0,
        SRC2 = 1'b1
    } src_e;

    // Handshake: a word moves on a rising edge when its valid and ready are both
    // high in that cycle; ready depends combinationally on valid and ready_i,
    // and the sources must not make valid depend on ready.
    src_e          r_owner;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_data;
    logic          r_valid;
    logic          r_src;

    src_e          w_owner_nxt;
    src_e          w_other;
    src_e          w_gnt_src;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_out_free;
    logic          w_own_valid;
    logic          w_oth_valid;
    logic          w_gnt;
    logic [N-1:0]  w_gnt_data;

    assign w_out_free  = !r_valid || ready_i;
    assign w_other     = (r_owner == SRC1) ? SRC2 : SRC1;
    assign w_own_valid = (r_owner == SRC2) ? valid2_i : valid1_i;
    assign w_oth_valid = (r_owner == SRC2) ? valid1_i : valid2_i;

    always_comb begin
        w_gnt       = 1'b0;
        w_gnt_src   = r_owner;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        if (w_own_valid && (r_cnt < BURST_C)) begin
            w_gnt     = 1'b1;
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (w_oth_valid) begin
            w_gnt       = 1'b1;
            w_gnt_src   = w_other;
            w_owner_nxt = w_other;
            w_cnt_nxt   = CW'(1);
        end else if (w_own_valid) begin
            // Burst exhausted but the other side is idle: restart without a bubble.
            w_gnt     = 1'b1;
            w_cnt_nxt = CW'(1);
        end else begin
            w_cnt_nxt = '0;
        end
    end

    assign w_gnt_data = (w_gnt_src == SRC2) ? data2_i : data1_i;
    assign ready1_o   = w_out_free && w_gnt && (w_gnt_src == SRC1);
    assign ready2_o   = w_out_free && w_gnt && (w_gnt_src == SRC2);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_owner <= SRC1;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_src   <= 1'b0;
        end else if (w_out_free) begin
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_gnt;
            if (w_gnt) begin
                r_data <= w_gnt_data;
                r_src  <= (w_gnt_src == SRC2);
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign src_o   = r_src;

endmodule

// File: tb/tb_merge_2.sv
// Self-checking bench for merge_2 (BURST = 2): directed literal scenarios plus a
// randomized run compared every cycle against a behavioural arbitration model.
module tb_merge_2;
    localparam int N = 8;
    localparam int B = 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] data1, data2, data_o;
    logic         valid1, valid2, ready1, ready2, valid_o, src_o, ready_i;

    int n_chk  = 0;
    int n_fail = 0;

    merge_2 #(.N(N), .BURST(B)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .data1_i (data1),
        .valid1_i(valid1),
        .ready1_o(ready1),
        .data2_i (data2),
        .valid2_i(valid2),
        .ready2_o(ready2),
        .data_o  (data_o),
        .valid_o (valid_o),
        .src_o   (src_o),
        .ready_i (ready_i)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // behavioural model: who owns the current run, how long it is, and what
    // the output register must hold
    int           run_src = 0;
    int           run_len = 0;
    logic         m_valid = 1'b0;
    logic [N-1:0] m_data  = '0;
    logic         m_src   = 1'b0;
    logic         take1   = 1'b0;
    logic         take2   = 1'b0;
    logic [N:0]   exp_q[$];

    always @(negedge clk) begin
        int   g;
        logic free;
        logic [N:0] w;
        logic v [2];
        if (!rst_n) begin
            run_src = 0;
            run_len = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 1'b0;
            take1   = 1'b0;
            take2   = 1'b0;
            exp_q.delete();
            chk("rst_valid_o", 32'(valid_o), 32'd0);
            chk("rst_data_o", 32'(data_o), 32'd0);
            chk("rst_src_o", 32'(src_o), 32'd0);
        end else begin
            chk("model_valid_o", 32'(valid_o), 32'(m_valid));
            if (m_valid) begin
                chk("model_data_o", 32'(data_o), 32'(m_data));
                chk("model_src_o", 32'(src_o), 32'(m_src));
                if (ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("stream_underflow", 32'd1, 32'd0);
                    end else begin
                        w = exp_q.pop_front();
                        chk("stream_word", 32'({src_o, data_o}), 32'(w));
                    end
                end
            end
            v[0] = valid1;
            v[1] = valid2;
            free = !m_valid || ready_i;
            g = -1;
            if (v[run_src] && run_len < B) begin
                g = run_src;
            end else if (v[1 - run_src]) begin
                g = 1 - run_src;
            end else if (v[run_src]) begin
                g = run_src;
            end
            chk("model_ready1", 32'(ready1), 32'(free && g == 0));
            chk("model_ready2", 32'(ready2), 32'(free && g == 1));
            take1 = free && g == 0;
            take2 = free && g == 1;
            if (free) begin
                if (g < 0) begin
                    run_len = 0;
                    m_valid = 1'b0;
                end else begin
                    run_len = (g == run_src) && run_len < B ? run_len + 1 : 1;
                    run_src = g;
                    m_valid = 1'b1;
                    m_data  = (g == 0) ? data1 : data2;
                    m_src   = (g == 1);
                    exp_q.push_back({m_src, m_data});
                end
            end
        end
    end

    // stimulus
    initial begin
        logic [N-1:0] exp_d;
        logic         exp_s;
        logic [7:0]   src_pat;
        rst_n   = 1'b1;
        valid1  = 1'b1;
        valid2  = 1'b1;
        data1   = 8'h77;
        data2   = 8'h88;
        ready_i = 1'b1;

        // reset with both sources valid
        #2 rst_n = 1'b0;
        #1;
        chk("reset_valid_o", 32'(valid_o), 32'd0);
        chk("reset_data_o", 32'(data_o), 32'd0);
        chk("reset_src_o", 32'(src_o), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("first_ready1", 32'(ready1), 32'd1);
        chk("first_ready2", 32'(ready2), 32'd0);
        step();
        chk("first_src", 32'(src_o), 32'd0);
        chk("first_data", 32'(data_o), 32'h77);
        valid1 = 1'b0;
        valid2 = 1'b0;
        step();

        // single source, no gaps
        valid1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data1 = 8'h11 + 8'(i);
            step();
            chk("single_valid", 32'(valid_o), 32'd1);
            chk("single_data", 32'(data_o), 32'(8'h11 + 8'(i)));
            chk("single_src", 32'(src_o), 32'd0);
        end
        valid1 = 1'b0;
        step();

        // contention: 0,0,1,1,0,0,1,1
        src_pat = 8'b1100_1100;
        valid1  = 1'b1;
        valid2  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data1 = 8'h30 + 8'(i);
            data2 = 8'h40 + 8'(i);
            step();
            exp_s = src_pat[i];
            exp_d = exp_s ? 8'h40 + 8'(i) : 8'h30 + 8'(i);
            chk("contend_src", 32'(src_o), 32'(exp_s));
            chk("contend_data", 32'(data_o), 32'(exp_d));
        end
        valid1 = 1'b0;
        valid2 = 1'b0;
        step();

        // backpressure holding 0xA5
        valid1 = 1'b1;
        data1  = 8'hA5;
        step();
        chk("bp_load", 32'(data_o), 32'hA5);
        data1   = 8'hB6;
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data", 32'(data_o), 32'hA5);
            chk("bp_hold_valid", 32'(valid_o), 32'd1);
            chk("bp_ready1", 32'(ready1), 32'd0);
            chk("bp_ready2", 32'(ready2), 32'd0);
        end
        ready_i = 1'b1;
        #1;
        chk("bp_release_ready1", 32'(ready1), 32'd1);
        step();
        chk("bp_next_data", 32'(data_o), 32'hB6);
        valid1 = 1'b0;
        step();
        chk("bp_drain_valid", 32'(valid_o), 32'd0);

        // burst restart on a lone source
        valid2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data2 = 8'h50 + 8'(i);
            step();
            chk("restart_valid", 32'(valid_o), 32'd1);
            chk("restart_src", 32'(src_o), 32'd1);
            chk("restart_data", 32'(data_o), 32'(8'h50 + 8'(i)));
        end
        valid2 = 1'b0;
        step();

        // reset mid-transfer
        valid1 = 1'b1;
        data1  = 8'h61;
        step();
        chk("mid_loaded", 32'(valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_data", 32'(data_o), 32'd0);
        valid2 = 1'b1;
        step();
        rst_n = 1'b1;
        src_pat = 8'b0000_1100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_resume_src", 32'(src_o), 32'(src_pat[i]));
        end

        // randomized traffic against the model
        data1 = 8'h00;
        data2 = 8'h80;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (take1) data1 = data1 + 8'd1;
            if (take2) data2 = data2 + 8'd1;
            valid1  = ($urandom_range(0, 3) != 0);
            valid2  = ($urandom_range(0, 2) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            if (i == 1500) rst_n = 1'b0;
            if (i == 1503) rst_n = 1'b1;
        end
        valid1  = 1'b0;
        valid2  = 1'b0;
        ready_i = 1'b1;
        step();
        step();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
